pe_conv_mac: RTL and testbench

//  Downstream consumer of the PE fmap scratch pad. It walks pad addresses on fmap_ready_to_pe and

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_psum_if.sv | 20 ++
 rtl/pe_mac_unit.sv | 39 +++
 rtl/pe_conv_mac.sv | 183 ++++++++++++++++++
 tb/tb_pe_conv_mac.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE convolution MAC slice.
package pe_pkg;

  localparam int DATA_WIDTH         = 16;
  localparam int ACC_WIDTH          = 40;
  localparam int ADDRESSWIDTH_F_PAD = 8;
  localparam int ADDRESSWIDTH_W_PAD = 8;
  localparam int DRAIN_CYCLES       = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PSUM,
    MAC,
    DRAIN,
    OUT
  } state_t;

  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(
    input logic signed [2*DATA_WIDTH-1:0] p
  );
    return {{(ACC_WIDTH-2*DATA_WIDTH){p[2*DATA_WIDTH-1]}}, p};
  endfunction

endpackage

// File: rtl/pe_psum_if.sv
// Psum result bus with valid/ready handshake.
interface pe_psum_if
  import pe_pkg::*;
;
  logic signed [ACC_WIDTH-1:0] psum_out;
  logic                        psum_valid;
  logic                        psum_ready;

  modport master (
    output psum_out,
    output psum_valid,
    input  psum_ready
  );

  modport slave (
    input  psum_out,
    input  psum_valid,
    output psum_ready
  );
endinterface

// File: rtl/pe_mac_unit.sv
// Registered signed product followed by a wrapping accumulator.
module pe_mac_unit
  import pe_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         load,
  input  logic                         acc_en,
  input  logic signed [ACC_WIDTH-1:0]  load_val,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
    end else begin
      prod <= a * b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else begin
      unique case (1'b1)
        clr:     acc <= '0;
        load:    acc <= load_val;
        acc_en:  acc <= acc + sext_prod(prod);
        default: acc <= acc;
      endcase
    end
  end

endmodule

// File: rtl/pe_conv_mac.sv
// Stride-1 1-D convolution PE: FSM, pad addressing and psum handshake.
// Optional PSUM_ACC_EN seeds each output's accumulator from psum_in.
module pe_conv_mac
  import pe_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 fmap_ready_to_pe,
  input  logic [ADDRESSWIDTH_F_PAD-1:0]        pixel_point,
  input  logic [ADDRESSWIDTH_F_PAD-1:0]        out_num,
  input  logic [ADDRESSWIDTH_W_PAD-1:0]        weight_num,
  output logic [ADDRESSWIDTH_F_PAD-1:0]        raddra_ifmap,
  input  logic signed [DATA_WIDTH-1:0]         fmap_out,
  output logic [ADDRESSWIDTH_W_PAD-1:0]        raddr_w,
  input  logic signed [DATA_WIDTH-1:0]         weight_out,
`ifdef PSUM_ACC_EN
  input  logic signed [ACC_WIDTH-1:0]          psum_in,
  input  logic                                 psum_in_valid,
  output logic                                 psum_in_ready,
`endif
  pe_psum_if.master                            psum,
  output logic                                 pe_busy,
  output logic                                 pe_done,
  output logic                                 start_overrun
);

  state_t                        state;
  logic [ADDRESSWIDTH_F_PAD-1:0] base_q;
  logic [ADDRESSWIDTH_F_PAD-1:0] num_q;
  logic [ADDRESSWIDTH_F_PAD-1:0] o_q;
  logic [ADDRESSWIDTH_W_PAD-1:0] wn_q;
  logic [ADDRESSWIDTH_W_PAD-1:0] k_q;
  logic [1:0]                    drain_q;
  logic                          v1_q;
  logic                          v2_q;
  logic                          accept;
  logic                          hs;
  logic                          clr;
  logic                          load;
  logic signed [ACC_WIDTH-1:0]   load_val;
  logic signed [ACC_WIDTH-1:0]   acc;

  // A start coinciding with pe_done is dropped: only a quiet IDLE accepts.
  assign accept = fmap_ready_to_pe && (state == IDLE) && !pe_done;
  assign hs     = (state == OUT) && psum.psum_ready;
  assign clr    = accept || hs;

`ifdef PSUM_ACC_EN
  assign load     = (state == WAIT_PSUM) && psum_in_valid;
  assign load_val = psum_in;
`else
  assign load     = 1'b0;
  assign load_val = '0;
`endif

  assign psum.psum_out = acc;

  // Tap valid travels with the pad read and product stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= (state == MAC);
      v2_q <= v1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      base_q          <= '0;
      num_q           <= '0;
      o_q             <= '0;
      wn_q            <= '0;
      k_q             <= '0;
      drain_q         <= '0;
      raddra_ifmap    <= '0;
      raddr_w         <= '0;
      psum.psum_valid <= 1'b0;
      pe_busy         <= 1'b0;
      pe_done         <= 1'b0;
      start_overrun   <= 1'b0;
`ifdef PSUM_ACC_EN
      psum_in_ready   <= 1'b0;
`endif
    end else begin
      pe_done <= 1'b0;
      if (fmap_ready_to_pe && state != IDLE) begin
        start_overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            base_q        <= pixel_point;
            num_q         <= out_num;
            wn_q          <= weight_num;
            o_q           <= '0;
            start_overrun <= 1'b0;
            if (out_num == '0 || weight_num == '0) begin
              pe_done <= 1'b1;
            end else begin
              pe_busy <= 1'b1;
`ifdef PSUM_ACC_EN
              state         <= WAIT_PSUM;
              psum_in_ready <= 1'b1;
`else
              state         <= MAC;
              raddra_ifmap  <= pixel_point;
              raddr_w       <= '0;
              k_q           <= '0;
`endif
            end
          end
        end
`ifdef PSUM_ACC_EN
        WAIT_PSUM: begin
          if (psum_in_valid) begin
            state         <= MAC;
            psum_in_ready <= 1'b0;
            raddra_ifmap  <= base_q + o_q;
            raddr_w       <= '0;
            k_q           <= '0;
          end
        end
`endif
        MAC: begin
          if (k_q == wn_q - 1'b1) begin
            state   <= DRAIN;
            drain_q <= '0;
          end else begin
            k_q          <= k_q + 1'b1;
            raddra_ifmap <= raddra_ifmap + 1'b1;
            raddr_w      <= raddr_w + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
            state           <= OUT;
            psum.psum_valid <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        OUT: begin
          if (psum.psum_ready) begin
            psum.psum_valid <= 1'b0;
            if (o_q == num_q - 1'b1) begin
              state   <= IDLE;
              pe_busy <= 1'b0;
              pe_done <= 1'b1;
            end else begin
              o_q <= o_q + 1'b1;
`ifdef PSUM_ACC_EN
              state         <= WAIT_PSUM;
              psum_in_ready <= 1'b1;
`else
              state         <= MAC;
              raddra_ifmap  <= base_q + o_q + 1'b1;
              raddr_w       <= '0;
              k_q           <= '0;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pe_mac_unit u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .acc_en   (v2_q),
    .load_val (load_val),
    .a        (fmap_out),
    .b        (weight_out),
    .acc      (acc)
  );

endmodule

// File: tb/tb_pe_conv_mac.sv
// Self-checking bench for pe_conv_mac with a behavioural convolution model.
module tb_pe_conv_mac;
  import pe_pkg::*;

`ifdef PSUM_ACC_EN
  localparam longint INIT  = -5;
  localparam int     EXTRA = 1;
`else
  localparam longint INIT  = 0;
  localparam int     EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pixel_point = '0;
  logic [7:0]  out_num = '0;
  logic [7:0]  weight_num = '0;
  logic [7:0]  raddra_ifmap;
  logic [7:0]  raddr_w;
  logic signed [15:0] fmap_out;
  logic signed [15:0] weight_out;
  logic        pe_busy;
  logic        pe_done;
  logic        start_overrun;
`ifdef PSUM_ACC_EN
  logic signed [39:0] psum_in = -40'sd5;
  logic        psum_in_valid = 1'b1;
  logic        psum_in_ready;
`endif

  pe_psum_if bus ();

  logic signed [15:0] f_mem [256];
  logic signed [15:0] w_mem [256];

  int n_checks = 0;
  int n_errors = 0;
  int ncyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic signed [39:0] exp_q [$];
  logic signed [39:0] got_q [$];
  int rise_q [$];
  logic signed [39:0] last_psum = '0;

  logic               prev_stall = 1'b0;
  logic               prev_valid = 1'b0;
  logic signed [39:0] prev_psum = '0;
  logic [7:0]         prev_fa = '0;
  logic [7:0]         prev_wa = '0;

  pe_conv_mac dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fmap_ready_to_pe (start),
    .pixel_point      (pixel_point),
    .out_num          (out_num),
    .weight_num       (weight_num),
    .raddra_ifmap     (raddra_ifmap),
    .fmap_out         (fmap_out),
    .raddr_w          (raddr_w),
    .weight_out       (weight_out),
`ifdef PSUM_ACC_EN
    .psum_in          (psum_in),
    .psum_in_valid    (psum_in_valid),
    .psum_in_ready    (psum_in_ready),
`endif
    .psum             (bus),
    .pe_busy          (pe_busy),
    .pe_done          (pe_done),
    .start_overrun    (start_overrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read pad models
  always @(posedge clk) begin
    fmap_out   <= f_mem[raddra_ifmap];
    weight_out <= w_mem[raddr_w];
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act),
               $signed(exp));
    end
  endtask

  function automatic logic signed [39:0] model(int base, int o, int wn);
    longint s = INIT;
    for (int k = 0; k < wn; k++)
      s += longint'(w_mem[k]) * longint'(f_mem[(base + o + k) % 256]);
    return s[39:0];
  endfunction

  task automatic push_job(int base, int on, int wn);
    if (wn > 0)
      for (int o = 0; o < on; o++) exp_q.push_back(model(base, o, wn));
  endtask

  task automatic start_job(input int base, input int on, input int wn,
                           output int s);
    @(posedge clk); #1;
    s = ncyc + 1;
    pixel_point = 8'(base);
    out_num = 8'(on);
    weight_num = 8'(wn);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
    end
    check("done_timeout", 64'(done_cnt != d0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check("done_once", 64'(done_cnt), 64'(d0 + 1));
    check("exp_drained", 64'(exp_q.size()), 64'(0));
  endtask

  // Compare process: psum values, hold-under-stall, done pulses
  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.psum_valid), 64'(1));
        check("hold_psum", 64'(bus.psum_out), 64'(prev_psum));
        check("hold_faddr", 64'(raddra_ifmap), 64'(prev_fa));
        check("hold_waddr", 64'(raddr_w), 64'(prev_wa));
      end
      if (bus.psum_valid && !prev_valid) begin
        rise_q.push_back(ncyc);
        check("valid_expected", 64'(exp_q.size() > 0), 64'(1));
      end
      if (bus.psum_valid && bus.psum_ready) begin
        if (exp_q.size() > 0)
          check("psum", 64'(bus.psum_out), 64'(exp_q.pop_front()));
        got_q.push_back(bus.psum_out);
        last_psum = bus.psum_out;
        hs_cnt++;
      end
      if (pe_done) done_cnt++;
      prev_stall = bus.psum_valid && !bus.psum_ready;
      prev_valid = bus.psum_valid;
      prev_psum  = bus.psum_out;
      prev_fa    = raddra_ifmap;
      prev_wa    = raddr_w;
    end else begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d0;
    int h0;
    int addr_exp [4];
    for (int i = 0; i < 256; i++) begin
      f_mem[i] = 16'(i);
      w_mem[i] = '0;
    end
    for (int i = 0; i < 4; i++) w_mem[i] = 16'(i + 1);
    bus.psum_ready = 1'b1;

    // Reset state
    #1;
    check("rst_faddr", 64'(raddra_ifmap), 64'(0));
    check("rst_waddr", 64'(raddr_w), 64'(0));
    check("rst_valid", 64'(bus.psum_valid), 64'(0));
    check("rst_psum", 64'(bus.psum_out), 64'(0));
    check("rst_busy", 64'(pe_busy), 64'(0));
    check("rst_done", 64'(pe_done), 64'(0));
    check("rst_overrun", 64'(start_overrun), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: basic job, latency and values
    rise_q.delete();
    got_q.delete();
    d0 = done_cnt;
    push_job(0, 3, 3);
    start_job(0, 3, 3, s);
    check("t1_busy", 64'(pe_busy), 64'(1));
    wait_done(d0);
    check("t1_count", 64'(got_q.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      check("t1_rise", 64'(rise_q.size() > i ? rise_q[i] : -1),
            64'(s + (i + 1) * (6 + EXTRA)));
    check("t1_p0", 64'(got_q.size() > 0 ? got_q[0] : 40'sd0), 64'(8 + INIT));
    check("t1_p1", 64'(got_q.size() > 1 ? got_q[1] : 40'sd0), 64'(14 + INIT));
    check("t1_p2", 64'(got_q.size() > 2 ? got_q[2] : 40'sd0), 64'(20 + INIT));

    // 2: consumer stalls the second psum for 10 cycles
    got_q.delete();
    d0 = done_cnt;
    h0 = hs_cnt;
    push_job(0, 3, 3);
    start_job(0, 3, 3, s);
    for (int i = 0; i < 200 && hs_cnt == h0; i++) begin
      @(posedge clk); #1;
    end
    bus.psum_ready = 1'b0;
    for (int i = 0; i < 200 && !bus.psum_valid; i++) begin
      @(posedge clk); #1;
    end
    check("t2_valid", 64'(bus.psum_valid), 64'(1));
    repeat (10) @(posedge clk);
    #1;
    check("t2_hold", 64'(bus.psum_out), 64'(14 + INIT));
    bus.psum_ready = 1'b1;
    wait_done(d0);
    check("t2_p2", 64'(got_q.size() > 2 ? got_q[2] : 40'sd0), 64'(20 + INIT));

    // 3: address wrap at the top of the fmap pad
    addr_exp = '{254, 255, 0, 1};
    d0 = done_cnt;
    push_job(254, 1, 4);
    start_job(254, 1, 4, s);
    repeat (EXTRA) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_faddr", 64'(raddra_ifmap), 64'(addr_exp[k]));
      check("t3_waddr", 64'(raddr_w), 64'(k));
    end
    wait_done(d0);
    check("t3_psum", 64'(last_psum), 64'(768 + INIT));

    // 4: zero-length jobs
    d0 = done_cnt;
    start_job(5, 3, 0, s);
    @(negedge clk);
    check("t4_done_wn0", 64'(pe_done), 64'(1));
    check("t4_busy", 64'(pe_busy), 64'(0));
    repeat (4) @(posedge clk);
    start_job(5, 0, 3, s);
    @(negedge clk);
    check("t4_done_on0", 64'(pe_done), 64'(1));
    repeat (10) @(posedge clk);
    #1;
    check("t4_done_cnt", 64'(done_cnt), 64'(d0 + 2));
    check("t4_no_valid", 64'(bus.psum_valid), 64'(0));

    // 5: start while busy
    d0 = done_cnt;
    push_job(0, 3, 3);
    start_job(0, 3, 3, s);
    @(posedge clk); #1;
    pixel_point = 8'd99;
    out_num = 8'd7;
    weight_num = 8'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t5_overrun", 64'(start_overrun), 64'(1));
    wait_done(d0);
    check("t5_sticky", 64'(start_overrun), 64'(1));

    // 6: most negative operands; accepted start clears overrun
    w_mem[0] = -16'sd32768;
    f_mem[10] = -16'sd32768;
    d0 = done_cnt;
    push_job(10, 1, 1);
    start_job(10, 1, 1, s);
    check("t6_overrun_clr", 64'(start_overrun), 64'(0));
    wait_done(d0);
    check("t6_psum", 64'(last_psum), 64'(longint'(1) << 30) + 64'(INIT));
    w_mem[0] = 16'sd1;
    f_mem[10] = 16'sd10;

    // Reset mid-MAC aborts the job
    d0 = done_cnt;
    start_job(20, 3, 8, s);
    repeat (2) @(posedge clk);
    #1;
    check("rm_busy", 64'(pe_busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rm_faddr", 64'(raddra_ifmap), 64'(0));
    check("rm_waddr", 64'(raddr_w), 64'(0));
    check("rm_valid", 64'(bus.psum_valid), 64'(0));
    check("rm_psum", 64'(bus.psum_out), 64'(0));
    check("rm_busy0", 64'(pe_busy), 64'(0));
    check("rm_done", 64'(pe_done), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("rm_no_done", 64'(done_cnt), 64'(d0));
    check("rm_no_valid", 64'(bus.psum_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
